wbm_initiator: RTL
==================

WBM_INITIATOR -- requirements
Module: wbm_initiator

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, Wishbone address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, Wishbone data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, max cycles to wait for termination; legal range 1..65535.
REQ-004 SHALL have a single clock and a synchronous, active-low reset, named as in the codebase.
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-007 SHALL have port cmd_valid, input, 1, command present.
REQ-008 SHALL have port cmd_ready, output, 1, command accepted when high with cmd_valid.
REQ-009 SHALL have port cmd_we, input, 1, 1 = write, 0 = read.
REQ-010 SHALL have port cmd_sel, input, DATA_WIDTH/8, byte lane enables.
REQ-011 SHALL have port cmd_addr, input, ADDR_WIDTH, target address.
REQ-012 SHALL have port cmd_wdata, input, DATA_WIDTH, write data.
REQ-013 SHALL have port rsp_valid, output, 1, response present.
REQ-014 SHALL have port rsp_ready, input, 1, response consumed when high with rsp_valid.
REQ-015 SHALL have port rsp_rdata, output, DATA_WIDTH, read data; 0 for writes and errors.
REQ-016 SHALL have port rsp_err, output, 1, bus error or timeout.
REQ-017 SHALL have port wbm_cyc_o, output, 1, Wishbone cycle.
REQ-018 SHALL have port wbm_stb_o, output, 1, Wishbone strobe.
REQ-019 SHALL have port wbm_we_o, output, 1, Wishbone write enable.
REQ-020 SHALL have port wbm_sel_o, output, DATA_WIDTH/8, byte selects.
REQ-021 SHALL have port wbm_adr_o, output, ADDR_WIDTH, address.
REQ-022 SHALL have port wbm_dat_o, output, DATA_WIDTH, write data.
REQ-023 SHALL have port wbm_ack_i, input, 1, slave acknowledge.
REQ-024 SHALL have port wbm_err_i, input, 1, slave error termination.
REQ-025 SHALL have port wbm_dat_i, input, DATA_WIDTH, slave read data.

Function
REQ-026 SHALL implement Wishbone classic single transfers, one outstanding, FSM states IDLE, BUS, RESP.
REQ-027 SHALL drive cmd_ready = 1 only in IDLE; all bus and response outputs registered.
REQ-028 SHALL, on cmd_valid & cmd_ready at edge N, register cmd fields to wbm_* outputs and assert wbm_cyc_o = wbm_stb_o = 1 from cycle N+1 (state BUS).
REQ-029 SHALL hold wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o stable throughout BUS.
REQ-030 SHALL, when wbm_ack_i sampled high in BUS, deassert cyc/stb next cycle, capture wbm_dat_i (reads) into rsp_rdata, set rsp_err = 0, rsp_valid = 1, enter RESP.
REQ-031 SHALL, when wbm_err_i sampled high in BUS, terminate as REQ-030 but rsp_err = 1, rsp_rdata = 0.
REQ-032 SHALL give priority ack > err when both high in the same cycle.
REQ-033 SHALL count BUS cycles in a counter cleared on entry; if count reaches TIMEOUT_CYCLES with no ack/err, terminate as REQ-031.
REQ-034 SHALL give priority ack/err > timeout when they coincide on the timeout cycle.
REQ-035 SHALL hold rsp_* stable in RESP until rsp_valid & rsp_ready; then rsp_valid = 0 and IDLE next cycle.
REQ-036 SHALL ignore wbm_ack_i/wbm_err_i outside BUS.
REQ-037 SHALL produce minimum latency: command edge N, ack at N+1 -> rsp_valid at N+2; next cmd_ready at N+3 if rsp_ready held high.

Reset
REQ-038 SHALL, when rst_n low at an edge, enter IDLE and drive cmd_ready = 1 (from next cycle), rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, wbm_cyc_o = wbm_stb_o = wbm_we_o = 0, wbm_sel_o = 0, wbm_adr_o = 0, wbm_dat_o = 0, timeout counter 0.
REQ-039 SHALL, on reset asserted mid-BUS or mid-RESP, abandon the transaction with no response.

Verification
REQ-040 SHALL cover: write cmd addr 0x3000_0010 data 0xDEAD_BEEF sel 0xF, slave acks 1 cycle after stb -> bus fields match, rsp_valid with rsp_err = 0, rsp_rdata = 0.
REQ-041 SHALL cover: read addr 0x3000_0004, slave acks after 3 wait cycles with 0x0000_07FF -> rsp_rdata = 0x0000_07FF, cyc/stb high exactly 4 cycles.
REQ-042 SHALL cover: TIMEOUT_CYCLES = 8, no ack -> cyc low after 8 BUS cycles, rsp_err = 1, rsp_rdata = 0.
REQ-043 SHALL cover: ack and err same cycle -> rsp_err = 0; ack on timeout cycle -> rsp_err = 0, data captured.
REQ-044 SHALL cover: rsp_ready low 5 cycles -> rsp fields stable, cmd_ready = 0, new cmd_valid not accepted until handshake.
REQ-045 SHALL cover: rst_n low during BUS -> all outputs at reset values next cycle, no rsp_valid, next command completes normally.

Source files
------------

// File: rtl/wbm_initiator.sv
// Wishbone classic single-transfer initiator: one command in flight, registered bus and
// response outputs, with a per-transfer timeout that terminates as a bus error.
module wbm_initiator #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_we,
  input  logic [DATA_WIDTH/8-1:0] cmd_sel,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    wbm_cyc_o,
  output logic                    wbm_stb_o,
  output logic                    wbm_we_o,
  output logic [DATA_WIDTH/8-1:0] wbm_sel_o,
  output logic [ADDR_WIDTH-1:0]   wbm_adr_o,
  output logic [DATA_WIDTH-1:0]   wbm_dat_o,
  input  logic                    wbm_ack_i,
  input  logic                    wbm_err_i,
  input  logic [DATA_WIDTH-1:0]   wbm_dat_i
);

  // Counter holds the index of the current BUS cycle; the last allowed one is TIMEOUT_CYCLES-1.
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  state_e      state_q;
  logic [15:0] tmo_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      tmo_cnt_q <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid && cmd_ready) begin
            state_q   <= StBus;
            tmo_cnt_q <= '0;
            cmd_ready <= 1'b0;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= cmd_we;
            wbm_sel_o <= cmd_sel;
            wbm_adr_o <= cmd_addr;
            wbm_dat_o <= cmd_wdata;
          end
        end
        StBus: begin
          // ack beats err, and either beats the timeout on the same cycle
          if (wbm_ack_i) begin
            state_q   <= StResp;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= wbm_we_o ? '0 : wbm_dat_i;
          end else if (wbm_err_i || (tmo_cnt_q == TimeoutLast)) begin
            state_q   <= StResp;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            state_q   <= StIdle;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: begin
          state_q   <= StIdle;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b0;
          wbm_cyc_o <= 1'b0;
          wbm_stb_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
